// File: rtl/coincidence_trigger.sv
// rtl/coincidence_trigger.sv - N-channel coincidence trigger with dead time, timestamp and event FIFO
module coincidence_trigger #(
    parameter int N_CH    = 8,
    parameter int WIN_W   = 4,
    parameter int DEAD_W  = 8,
    parameter int TS_W    = 24,
    parameter int FIFO_AW = 2,
    parameter int THR_W   = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              enable,
    input  logic [N_CH-1:0]   ch_in,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic [THR_W-1:0]  threshold,
    input  logic [WIN_W-1:0]  window,
    input  logic [DEAD_W-1:0] deadtime,
    output logic              trig_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [N_CH-1:0]   evt_pattern,
    output logic [TS_W-1:0]   evt_time,
    output logic [15:0]       drop_count,
    output logic              busy
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DEAD} state_t;

    state_t              r_state;
    logic [DEAD_W-1:0]   r_dead;
    logic                r_trig;
    logic [TS_W-1:0]     r_ts;
    logic [N_CH-1:0]     r_s1, r_s2, r_s3;
    logic [WIN_W-1:0]    r_cnt [N_CH];
    logic [N_CH-1:0]     r_mem_pat [DEPTH];
    logic [TS_W-1:0]     r_mem_ts  [DEPTH];
    logic [FIFO_AW-1:0]  r_wr, r_rd;
    logic [FIFO_AW:0]    r_count;
    logic [15:0]         r_drop;

    logic [N_CH-1:0]     w_rise;
    logic [N_CH-1:0]     w_active;
    logic [N_CH-1:0]     w_hits;
    logic [THR_W-1:0]    w_popcnt;
    logic                w_coinc;
    logic                w_fire;
    logic                w_pop;
    logic                w_full;
    logic                w_accept;

    assign w_rise   = r_s2 & ~r_s3;
    assign w_hits   = w_active & ch_mask;
    assign w_coinc  = (threshold != '0) && (w_popcnt >= threshold);
    assign w_fire   = (r_state == S_ARMED) && enable && w_coinc;
    assign w_pop    = evt_valid && evt_ready;
    assign w_full   = (r_count == FULL_CNT);
    // A push into a full FIFO is still taken when the head leaves in the same cycle
    assign w_accept = w_fire && (!w_full || w_pop);

    // Per-channel activity flags and masked hit count
    always_comb begin
        w_popcnt = '0;
        w_active = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_active[i] = (r_cnt[i] != '0);
            w_popcnt    = w_popcnt + THR_W'(w_hits[i]);
        end
    end

    // Synchronise asynchronous channel levels and keep one history stage for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= ch_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Stretch each rising edge into a window; cleared on trigger so one burst fires once
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
        end else if (r_state == S_IDLE || w_fire) begin
            for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_rise[i])
                    r_cnt[i] <= window;
                else if (r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - WIN_W'(1);
            end
        end
    end

    // Free-running timestamp, independent of enable
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_ts <= '0;
        else        r_ts <= r_ts + TS_W'(1);
    end

    // Trigger FSM: arm, fire, hold off for deadtime cycles; enable low forces idle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_dead  <= '0;
            r_trig  <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            if (!enable) begin
                r_state <= S_IDLE;
                r_dead  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_ARMED;
                    S_ARMED: begin
                        if (w_coinc) begin
                            r_trig  <= 1'b1;
                            r_dead  <= deadtime;
                            r_state <= (deadtime == '0) ? S_ARMED : S_DEAD;
                        end
                    end
                    S_DEAD: begin
                        if (r_dead <= DEAD_W'(1)) begin
                            r_dead  <= '0;
                            r_state <= S_ARMED;
                        end else begin
                            r_dead <= r_dead - DEAD_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Event FIFO with saturating drop counter for pushes that find it full
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pat[i] <= '0;
                r_mem_ts[i]  <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_accept) begin
                r_mem_pat[r_wr] <= w_hits;
                r_mem_ts[r_wr]  <= r_ts;
                r_wr            <= r_wr + FIFO_AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + FIFO_AW'(1);
            if (w_accept && !w_pop)
                r_count <= r_count + (FIFO_AW+1)'(1);
            else if (!w_accept && w_pop)
                r_count <= r_count - (FIFO_AW+1)'(1);
            if (w_fire && !w_accept && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;
        end
    end

    assign trig_pulse  = r_trig;
    assign evt_valid   = (r_count != '0);
    assign evt_pattern = r_mem_pat[r_rd];
    assign evt_time    = r_mem_ts[r_rd];
    assign drop_count  = r_drop;
    assign busy        = (r_state == S_DEAD);

endmodule

// File: tb/tb_coincidence_trigger.sv
// tb/tb_coincidence_trigger.sv - directed self-checking bench for coincidence_trigger
module tb_coincidence_trigger;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        enable;
    logic [7:0]  ch_in;
    logic [7:0]  ch_mask;
    logic [4:0]  threshold;
    logic [3:0]  window;
    logic [7:0]  deadtime;
    logic        trig_pulse;
    logic        evt_valid;
    logic        evt_ready;
    logic [7:0]  evt_pattern;
    logic [23:0] evt_time;
    logic [15:0] drop_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [23:0] m_ts;

    coincidence_trigger #(
        .N_CH(8), .WIN_W(4), .DEAD_W(8), .TS_W(24), .FIFO_AW(2), .THR_W(5)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .enable(enable), .ch_in(ch_in), .ch_mask(ch_mask),
        .threshold(threshold), .window(window), .deadtime(deadtime),
        .trig_pulse(trig_pulse), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_pattern(evt_pattern), .evt_time(evt_time), .drop_count(drop_count), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Reference timestamp: counts every cycle from reset
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) m_ts <= '0;
        else        m_ts <= m_ts + 24'd1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic configure(input logic [7:0] m, input logic [4:0] t, input logic [3:0] w, input logic [7:0] d);
        ch_mask = m; threshold = t; window = w; deadtime = d; enable = 1'b1;
        tick(3);
    endtask

    // Hold the pattern for exactly one sampling edge; returns just after that edge
    task automatic pulse(input logic [7:0] p);
        ch_in = p;
        tick(1);
        ch_in = 8'h00;
    endtask

    task automatic test_reset;
        RST_N = 1'b0; enable = 1'b0; evt_ready = 1'b0; ch_in = 8'h00;
        ch_mask = 8'h00; threshold = 5'd0; window = 4'd0; deadtime = 8'd0;
        tick(3);
        checks++; if ({trig_pulse, evt_valid, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {trig_pulse, evt_valid, busy}); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        checks++; if ({evt_pattern, evt_time} !== 32'd0) begin errors++; $display("FAIL reset_head got %h want 0", {evt_pattern, evt_time}); end
        RST_N = 1'b1;
        tick(2);
    endtask

    task automatic test_basic;
        logic [23:0] exp_t;
        configure(8'h03, 5'd2, 4'd4, 8'd0);
        pulse(8'h03);
        tick(2);
        checks++; if (trig_pulse !== 1'b0) begin errors++; $display("FAIL basic_early got %b want 0", trig_pulse); end
        tick(1);
        exp_t = m_ts - 24'd1;
        checks++; if ({trig_pulse, evt_valid} !== 2'b11) begin errors++; $display("FAIL basic_trig got %b want 11", {trig_pulse, evt_valid}); end
        checks++; if (evt_pattern !== 8'h03) begin errors++; $display("FAIL basic_pattern got %h want 03", evt_pattern); end
        checks++; if (evt_time !== exp_t) begin errors++; $display("FAIL basic_time got %0d want %0d", evt_time, exp_t); end
        tick(1);
        checks++; if ({trig_pulse, evt_valid} !== 2'b01) begin errors++; $display("FAIL basic_hold got %b want 01", {trig_pulse, evt_valid}); end
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %b want 0", evt_valid); end
    endtask

    task automatic test_window;
        int n;
        configure(8'h03, 5'd2, 4'd4, 8'd0);
        ch_in = 8'h01; tick(1); ch_in = 8'h00; tick(2);
        ch_in = 8'h02; tick(1); ch_in = 8'h00;
        n = 0; repeat (10) begin tick(1); n += int'(trig_pulse); end
        checks++; if (n != 1) begin errors++; $display("FAIL window_k3 got %0d triggers want 1", n); end
        checks++; if ({evt_valid, evt_pattern} !== 9'h103) begin errors++; $display("FAIL window_k3_evt got %h want 103", {evt_valid, evt_pattern}); end
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        ch_in = 8'h01; tick(1); ch_in = 8'h00; tick(3);
        ch_in = 8'h02; tick(1); ch_in = 8'h00;
        n = 0; repeat (10) begin tick(1); n += int'(trig_pulse); end
        checks++; if (n != 0 || evt_valid !== 1'b0) begin errors++; $display("FAIL window_k4 got %0d triggers valid %b want 0 0", n, evt_valid); end
        window = 4'd0; tick(2);
        pulse(8'h03);
        n = 0; repeat (8) begin tick(1); n += int'(trig_pulse); end
        checks++; if (n != 0) begin errors++; $display("FAIL window_zero got %0d triggers want 0", n); end
    endtask

    task automatic test_majority;
        int n;
        configure(8'hF0, 5'd3, 4'd4, 8'd0);
        pulse(8'h07);
        n = 0; repeat (8) begin tick(1); n += int'(trig_pulse); end
        checks++; if (n != 0 || evt_valid !== 1'b0) begin errors++; $display("FAIL maj_masked got %0d triggers valid %b want 0 0", n, evt_valid); end
        pulse(8'hB0);
        n = 0; repeat (8) begin tick(1); n += int'(trig_pulse); end
        checks++; if (n != 1) begin errors++; $display("FAIL maj_hit got %0d triggers want 1", n); end
        checks++; if ({evt_valid, evt_pattern} !== 9'h1B0) begin errors++; $display("FAIL maj_pattern got %h want 1B0", {evt_valid, evt_pattern}); end
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        configure(8'hFF, 5'd0, 4'd4, 8'd0);
        pulse(8'hFF);
        n = 0; repeat (8) begin tick(1); n += int'(trig_pulse); end
        checks++; if (n != 0 || evt_valid !== 1'b0) begin errors++; $display("FAIL thr_zero got %0d triggers valid %b want 0 0", n, evt_valid); end
    endtask

    task automatic test_deadtime;
        int nb;
        int nt;
        configure(8'h03, 5'd2, 4'd4, 8'd10);
        pulse(8'h03);
        tick(3);
        checks++; if ({trig_pulse, busy} !== 2'b11) begin errors++; $display("FAIL dead_first got %b want 11", {trig_pulse, busy}); end
        nb = 1; nt = 1;
        tick(1); nb += int'(busy); nt += int'(trig_pulse);
        ch_in = 8'h03; tick(1); ch_in = 8'h00; nb += int'(busy); nt += int'(trig_pulse);
        repeat (15) begin tick(1); nb += int'(busy); nt += int'(trig_pulse); end
        checks++; if (nb != 10) begin errors++; $display("FAIL dead_busy_len got %0d want 10", nb); end
        checks++; if (nt != 1) begin errors++; $display("FAIL dead_ignored got %0d triggers want 1", nt); end
        pulse(8'h03);
        tick(3);
        checks++; if ({trig_pulse, busy} !== 2'b11) begin errors++; $display("FAIL dead_third got %b want 11", {trig_pulse, busy}); end
        evt_ready = 1'b1; tick(1);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL dead_second_evt got %b want 1", evt_valid); end
        tick(1); evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL dead_two_evts got %b want 0", evt_valid); end
        tick(12);
    endtask

    task automatic test_fifo_full;
        int nt;
        logic [23:0] exp_t [6];
        configure(8'h03, 5'd2, 4'd4, 8'd0);
        evt_ready = 1'b0;
        nt = 0;
        for (int i = 0; i < 6; i++) begin
            pulse(8'h03); tick(3);
            nt += int'(trig_pulse); exp_t[i] = m_ts - 24'd1;
            tick(4);
        end
        checks++; if (nt != 6) begin errors++; $display("FAIL full_pulses got %0d want 6", nt); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL full_drops got %0d want 2", drop_count); end
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_time !== exp_t[i] || evt_pattern !== 8'h03) begin
                errors++; $display("FAIL full_pop%0d got v=%b t=%0d p=%h want v=1 t=%0d p=03", i, evt_valid, evt_time, evt_pattern, exp_t[i]);
            end
            tick(1);
        end
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", evt_valid); end
        for (int i = 0; i < 4; i++) begin
            pulse(8'h03); tick(3);
            exp_t[i] = m_ts - 24'd1;
            tick(4);
        end
        pulse(8'h03); tick(2);
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        exp_t[4] = m_ts - 24'd1;
        checks++; if ({trig_pulse, drop_count} !== {1'b1, 16'd2}) begin errors++; $display("FAIL full_pushpop got trig=%b drops=%0d want trig=1 drops=2", trig_pulse, drop_count); end
        evt_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_time !== exp_t[i]) begin
                errors++; $display("FAIL pushpop_pop%0d got v=%b t=%0d want v=1 t=%0d", i, evt_valid, evt_time, exp_t[i]);
            end
            tick(1);
        end
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty got %b want 0", evt_valid); end
    endtask

    task automatic test_reset_mid;
        configure(8'h03, 5'd2, 4'd4, 8'd0);
        pulse(8'h03); tick(8);
        deadtime = 8'd50; tick(1);
        pulse(8'h03); tick(3);
        checks++; if ({busy, evt_valid} !== 2'b11) begin errors++; $display("FAIL rstmid_pre got %b want 11", {busy, evt_valid}); end
        RST_N = 1'b0; #1;
        checks++; if ({trig_pulse, evt_valid, busy} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got %b want 000", {trig_pulse, evt_valid, busy}); end
        checks++; if ({drop_count, evt_pattern, evt_time} !== 48'd0) begin errors++; $display("FAIL rstmid_regs got %h want 0", {drop_count, evt_pattern, evt_time}); end
        tick(2); RST_N = 1'b1; tick(1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after got %b want 0", evt_valid); end
    endtask

    task automatic test_enable_drop;
        int n;
        configure(8'h03, 5'd2, 4'd4, 8'd0);
        pulse(8'h03); tick(8);
        deadtime = 8'd50; tick(1);
        pulse(8'h03); tick(3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL endrop_busy got %b want 1", busy); end
        enable = 1'b0; tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_idle got %b want 0", busy); end
        pulse(8'h03);
        n = 0; repeat (8) begin tick(1); n += int'(trig_pulse); end
        checks++; if (n != 0) begin errors++; $display("FAIL endrop_disarmed got %0d triggers want 0", n); end
        evt_ready = 1'b1;
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL endrop_q0 got %b want 1", evt_valid); end
        tick(1);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL endrop_q1 got %b want 1", evt_valid); end
        tick(1); evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL endrop_drained got %b want 0", evt_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window();
        test_majority();
        test_deadtime();
        test_fifo_full();
        test_reset_mid();
        test_enable_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coincidence_trigger.md
Name: coincidence_trigger

Overview:
Parametrised N-channel coincidence trigger for the MPPC telescope. It sits between the per-channel discriminated inputs and the serial/UART event readout. It replaces the fixed two-channel AND with the following features:
- per-channel edge detection and programmable window stretching
- channel masking
- majority threshold
- trigger dead time
- a free-running timestamp
- a small event FIFO with a valid/ready output handshake and a dropped-event counter

Parameters:
N_CH, 8, number of input channels (2..16)
WIN_W, 4, width of the coincidence-window setting and per-channel stretch counters
DEAD_W, 8, width of the dead-time setting and counter
TS_W, 24, timestamp width
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW
THR_W, 5, width of threshold input (must hold N_CH)

Ports:
CLK  in  1  system clock (9.6 MHz)
RST_N  in  1  asynchronous active-low reset
enable  in  1  arm trigger; low = idle
ch_in  in  N_CH  asynchronous discriminated channel levels
ch_mask  in  N_CH  1 = channel participates
threshold  in  THR_W  minimum number of coincident masked channels; 0 = never trigger
window  in  WIN_W  stretch length in cycles; 0 = channel never active
deadtime  in  DEAD_W  cycles of hold-off after a trigger
trig_pulse  out  1  one-cycle pulse per accepted or dropped trigger
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_pattern  out  N_CH  hit pattern of head event
evt_time  out  TS_W  timestamp of head event
drop_count  out  16  saturating count of triggers lost to a full FIFO
busy  out  1  high in DEAD state

Behaviour:
- Reset (RST_N low, async): all outputs 0, all counters 0, sync flops 0, FIFO empty, FSM IDLE.
- Input path per channel:
  - 2-flop synchroniser s1,s2 plus history flop s3.
  - rise = s2 & ~s3.
  - A rise sampled by the clock at edge k is visible as rise at edge k+2.
- Stretch counter per channel:
  - On rise (and FSM != IDLE), load window; otherwise decrement if nonzero.
  - A rise while the counter is nonzero reloads it.
  - active[i] = (cnt[i] != 0).
  - Counters are all cleared on a trigger and while in IDLE.
- Coincidence: popcount(active & ch_mask) >= threshold, with threshold != 0. Combinational; evaluated only in ARMED.
- Timestamp: TS_W free-running counter, increments every cycle from reset, wraps 2**TS_W-1 -> 0. It runs regardless of enable.
- FSM:
  - IDLE: enable=1 -> ARMED.
  - ARMED: on coincidence, at the same edge:
    - register trig_pulse=1
    - push {active&ch_mask, ts}
    - clear stretch counters
    - load dead counter with deadtime
    - go to DEAD, or stay ARMED if deadtime=0
  - DEAD: decrement the dead counter. When the counter reaches 1, go ARMED; that is exactly deadtime cycles in DEAD. Coincidences are ignored. Stretch counters still load on rises.
  - enable=0 in any state -> IDLE at the next edge; any pending dead time is discarded.
- Latency: the last contributing channel's edge sampled at edge k produces trig_pulse and evt_valid high in the cycle after edge k+3. evt_time equals the timestamp value held during that coincidence cycle.
- FIFO:
  - evt_valid = not empty; evt_pattern and evt_time show the head.
  - Pop on evt_valid & evt_ready.
  - Outputs are stable while evt_valid=1 and evt_ready=0.
  - Push when full and no pop in the same cycle: event dropped, drop_count += 1 saturating at 16'hFFFF, trig_pulse still asserted.
  - Push and pop in the same cycle when full: push accepted, occupancy unchanged.
  - Push and pop in the same cycle when empty: not possible (evt_valid=0).
  - FIFO contents and the readout handshake are unaffected by enable.
- Masked-out channels never contribute to the count or the pattern.

Test Plan:
- Basic two-fold: N_CH=8, mask=8'h03, thr=2, window=4, deadtime=0. Pulse ch0 and ch1 high on the same edge k -> trig_pulse in the cycle after k+3, evt_pattern=8'h03, evt_valid=1 until evt_ready.
- Window boundary: ch0 at edge k, ch1 at k+3 -> one trigger. ch0 at k, ch1 at k+4 -> no trigger. window=0 -> no trigger even with simultaneous hits.
- Majority and mask: thr=3, mask=8'hF0. Hit ch0..ch2 -> no trigger. Hit ch4, ch5, ch7 -> trigger with pattern 8'hB0.
- Dead time: deadtime=10, two coincidences 5 cycles apart -> one trigger, busy high for 10 cycles. A third coincidence after busy falls -> second event.
- FIFO full and drop: FIFO_AW=2, evt_ready=0, six coincidences -> 4 events stored, drop_count=2, six trig_pulses. Then hold evt_ready=1 -> 4 pops in order with increasing evt_time. Simultaneous push/pop when full -> accepted, drop_count unchanged.
- Reset/enable mid-operation: assert RST_N=0 while in DEAD with 2 events queued -> outputs 0 and FIFO empty immediately. Separately, drop enable during DEAD -> busy=0 next cycle, queued events still drain.
